// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multicycle controller and the shared MIPS-32 datapath.
interface multicycle_ctrl_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_we;
  logic       ir_we;
  logic       i_or_d;
  logic       mem_rd;
  logic       mem_wr;
  logic       reg_we;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic       ofs;
  logic [1:0] pc_src;
  logic       instr_done;
  logic       illegal;
  logic       bus_err;
  logic [3:0] state;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_we, ir_we, i_or_d, mem_rd, mem_wr, reg_we, reg_dst, mem_to_reg,
           alu_src_a, alu_src_b, alu_op, ofs, pc_src, instr_done, illegal,
           bus_err, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_we, ir_we, i_or_d, mem_rd, mem_wr, reg_we, reg_dst, mem_to_reg,
           alu_src_a, alu_src_b, alu_op, ofs, pc_src, instr_done, illegal,
           bus_err, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore FSM sequencing a shared MIPS-32 datapath (one ALU, one memory port, one register file),
// with a memory-ready handshake, wait timeout into HALT, and illegal-opcode reporting.
module multicycle_ctrl #(
  parameter int unsigned MEM_WAIT_MAX = 15,
  parameter int unsigned CNT_W        = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    EXEC_R = 4'd7,
    EXEC_I = 4'd8,
    ALUWB  = 4'd9,
    BRANCH = 4'd10,
    JUMP   = 4'd11,
    HALT   = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_XORI  = 6'd14;
  localparam logic [5:0] OP_SPEC2 = 6'd28;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  state_e           state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_err_q, bus_err_d;
  logic             waiting_c;
  logic             timeout_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= 6'd0;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Memory-wait accounting: a stall in any memory state counts toward the timeout.
  always_comb begin
    waiting_c = ((state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR)) && !bus.mem_ready;
    timeout_c = waiting_c && (cnt_q == CNT_W'(MEM_WAIT_MAX));
  end

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    bus_err_d      = bus_err_q;
    bus.pc_we      = 1'b0;
    bus.ir_we      = 1'b0;
    bus.i_or_d     = 1'b0;
    bus.mem_rd     = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.reg_we     = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.alu_op     = 3'b000;
    bus.ofs        = 1'b0;
    bus.pc_src     = 2'b00;
    bus.instr_done = 1'b0;
    bus.illegal    = 1'b0;

    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        bus.mem_rd    = 1'b1;
        bus.alu_src_b = 2'b01;
        if (bus.mem_ready) begin
          bus.ir_we = 1'b1;
          bus.pc_we = 1'b1;
          state_d   = DECODE;
        end
      end
      DECODE: begin
        bus.alu_src_b = 2'b11;
        op_d          = bus.opcode;
        case (bus.opcode)
          OP_LW, OP_SW:                                  state_d = MEMADR;
          OP_RTYPE, OP_SPEC2:                            state_d = EXEC_R;
          OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI:   state_d = EXEC_I;
          OP_BEQ, OP_BNE:                                state_d = BRANCH;
          OP_J:                                          state_d = JUMP;
          default: begin
            bus.illegal    = 1'b1;
            bus.instr_done = 1'b1;
            state_d        = FETCH;
          end
        endcase
      end
      MEMADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        state_d       = (op_q == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        bus.mem_rd = 1'b1;
        bus.i_or_d = 1'b1;
        if (bus.mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        bus.reg_we     = 1'b1;
        bus.mem_to_reg = 1'b1;
        bus.instr_done = 1'b1;
        state_d        = FETCH;
      end
      MEMWR: begin
        bus.mem_wr = 1'b1;
        bus.i_or_d = 1'b1;
        if (bus.mem_ready) begin
          bus.instr_done = 1'b1;
          state_d        = FETCH;
        end
      end
      EXEC_R: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 3'b010;
        state_d       = ALUWB;
      end
      EXEC_I: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.ofs       = (op_q == OP_ADDI);
        case (op_q)
          OP_ANDI: bus.alu_op = 3'b100;
          OP_ORI:  bus.alu_op = 3'b101;
          OP_XORI: bus.alu_op = 3'b110;
          default: bus.alu_op = 3'b000;
        endcase
        state_d = ALUWB;
      end
      ALUWB: begin
        bus.reg_we     = 1'b1;
        bus.reg_dst    = (op_q == OP_RTYPE) || (op_q == OP_SPEC2);
        bus.instr_done = 1'b1;
        state_d        = FETCH;
      end
      BRANCH: begin
        bus.alu_src_a  = 1'b1;
        bus.alu_op     = 3'b001;
        bus.pc_src     = 2'b01;
        bus.instr_done = 1'b1;
        bus.pc_we      = ((op_q == OP_BEQ) && bus.zero) || ((op_q == OP_BNE) && !bus.zero);
        state_d        = FETCH;
      end
      JUMP: begin
        bus.pc_src     = 2'b10;
        bus.pc_we      = 1'b1;
        bus.instr_done = 1'b1;
        state_d        = FETCH;
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase

    // A ready in the last allowed cycle still completes normally.
    if (timeout_c) begin
      bus_err_d = 1'b1;
      state_d   = HALT;
    end

    if (state_d != state_q) cnt_d = '0;
    else if (waiting_c)     cnt_d = cnt_q + CNT_W'(1);
    else                    cnt_d = cnt_q;
  end

  assign bus.state   = state_q;
  assign bus.bus_err = bus_err_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: table of instruction sequences plus hand-written
// corner cases (memory stalls, wait timeout, asynchronous reset), compared through a queue.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       pc_we;
    logic       ir_we;
    logic       i_or_d;
    logic       mem_rd;
    logic       mem_wr;
    logic       reg_we;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       ofs;
    logic [1:0] pc_src;
    logic       instr_done;
    logic       illegal;
    logic       bus_err;
    logic [3:0] state;
  } ctrl_t;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic        zero;
    int          len;
    logic [3:0]  seq [5];
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;
  ctrl_t exp_q[$];
  vec_t  vecs[15];

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.MEM_WAIT_MAX(15), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish, passed=%0d total=%0d", n_pass, n_total);
    $fatal(1);
  end

  function automatic logic legal_op(input logic [5:0] op);
    return op inside {6'd0, 6'd2, 6'd4, 6'd5, 6'd8, 6'd9, 6'd12, 6'd13, 6'd14, 6'd28, 6'd35, 6'd43};
  endfunction

  // Expected control word for one cycle, read straight off the state/output table.
  function automatic ctrl_t exp_out(input logic [3:0] st, input logic [5:0] op,
                                    input logic zero, input logic rdy);
    ctrl_t e;
    e = '0;
    e.state = st;
    case (st)
      4'd1: begin
        e.mem_rd = 1'b1; e.alu_src_b = 2'b01;
        e.ir_we = rdy; e.pc_we = rdy;
      end
      4'd2: begin
        e.alu_src_b = 2'b11;
        e.illegal = !legal_op(op); e.instr_done = !legal_op(op);
      end
      4'd3: begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
      4'd4: begin e.mem_rd = 1'b1; e.i_or_d = 1'b1; end
      4'd5: begin e.reg_we = 1'b1; e.mem_to_reg = 1'b1; e.instr_done = 1'b1; end
      4'd6: begin e.mem_wr = 1'b1; e.i_or_d = 1'b1; e.instr_done = rdy; end
      4'd7: begin e.alu_src_a = 1'b1; e.alu_op = 3'b010; end
      4'd8: begin
        e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.ofs = (op == 6'd8);
        e.alu_op = (op == 6'd12) ? 3'b100 : (op == 6'd13) ? 3'b101 :
                   (op == 6'd14) ? 3'b110 : 3'b000;
      end
      4'd9: begin
        e.reg_we = 1'b1; e.instr_done = 1'b1;
        e.reg_dst = (op == 6'd0) || (op == 6'd28);
      end
      4'd10: begin
        e.alu_src_a = 1'b1; e.alu_op = 3'b001; e.pc_src = 2'b01; e.instr_done = 1'b1;
        e.pc_we = ((op == 6'd4) && zero) || ((op == 6'd5) && !zero);
      end
      4'd11: begin e.pc_src = 2'b10; e.pc_we = 1'b1; e.instr_done = 1'b1; end
      4'd12: e.bus_err = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  function automatic ctrl_t sample();
    ctrl_t a;
    a.pc_we = bus.pc_we;         a.ir_we = bus.ir_we;       a.i_or_d = bus.i_or_d;
    a.mem_rd = bus.mem_rd;       a.mem_wr = bus.mem_wr;     a.reg_we = bus.reg_we;
    a.reg_dst = bus.reg_dst;     a.mem_to_reg = bus.mem_to_reg;
    a.alu_src_a = bus.alu_src_a; a.alu_src_b = bus.alu_src_b; a.alu_op = bus.alu_op;
    a.ofs = bus.ofs;             a.pc_src = bus.pc_src;     a.instr_done = bus.instr_done;
    a.illegal = bus.illegal;     a.bus_err = bus.bus_err;   a.state = bus.state;
    return a;
  endfunction

  task automatic check(input string name, input ctrl_t act, input ctrl_t exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got ctrl=%h (state %0d) expected ctrl=%h (state %0d)",
               name, act, act.state, exp, exp.state);
    else
      n_pass++;
  endtask

  // Called just after a rising edge: drive inputs, queue the expectation, compare mid-cycle.
  task automatic step(input string name, input logic [3:0] st, input logic [5:0] op,
                      input logic zero, input logic rdy);
    ctrl_t e;
    bus.opcode = op; bus.zero = zero; bus.mem_ready = rdy;
    exp_q.push_back(exp_out(st, op, zero, rdy));
    @(negedge clk);
    e = exp_q.pop_front();
    check(name, sample(), e);
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input string name, input logic [5:0] op, input logic zero,
                              input int len, input logic [3:0] s0, input logic [3:0] s1,
                              input logic [3:0] s2, input logic [3:0] s3, input logic [3:0] s4);
    vec_t v;
    v.name = name; v.op = op; v.zero = zero; v.len = len;
    v.seq[0] = s0; v.seq[1] = s1; v.seq[2] = s2; v.seq[3] = s3; v.seq[4] = s4;
    return v;
  endfunction

  initial begin
    n_pass = 0; n_total = 0;
    vecs[0]  = mk("lw",       6'd35, 1'b0, 5, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5);
    vecs[1]  = mk("sw",       6'd43, 1'b0, 4, 4'd1, 4'd2, 4'd3, 4'd6, 4'd0);
    vecs[2]  = mk("rtype",    6'd0,  1'b0, 4, 4'd1, 4'd2, 4'd7, 4'd9, 4'd0);
    vecs[3]  = mk("special2", 6'd28, 1'b1, 4, 4'd1, 4'd2, 4'd7, 4'd9, 4'd0);
    vecs[4]  = mk("beq_tk",   6'd4,  1'b1, 3, 4'd1, 4'd2, 4'd10, 4'd0, 4'd0);
    vecs[5]  = mk("beq_nt",   6'd4,  1'b0, 3, 4'd1, 4'd2, 4'd10, 4'd0, 4'd0);
    vecs[6]  = mk("bne_tk",   6'd5,  1'b0, 3, 4'd1, 4'd2, 4'd10, 4'd0, 4'd0);
    vecs[7]  = mk("bne_nt",   6'd5,  1'b1, 3, 4'd1, 4'd2, 4'd10, 4'd0, 4'd0);
    vecs[8]  = mk("j",        6'd2,  1'b0, 3, 4'd1, 4'd2, 4'd11, 4'd0, 4'd0);
    vecs[9]  = mk("addi",     6'd8,  1'b0, 4, 4'd1, 4'd2, 4'd8, 4'd9, 4'd0);
    vecs[10] = mk("addiu",    6'd9,  1'b0, 4, 4'd1, 4'd2, 4'd8, 4'd9, 4'd0);
    vecs[11] = mk("andi",     6'd12, 1'b0, 4, 4'd1, 4'd2, 4'd8, 4'd9, 4'd0);
    vecs[12] = mk("ori",      6'd13, 1'b0, 4, 4'd1, 4'd2, 4'd8, 4'd9, 4'd0);
    vecs[13] = mk("xori",     6'd14, 1'b1, 4, 4'd1, 4'd2, 4'd8, 4'd9, 4'd0);
    vecs[14] = mk("illegal63", 6'd63, 1'b0, 2, 4'd1, 4'd2, 4'd0, 4'd0, 4'd0);

    rst_n = 1'b0; bus.opcode = 6'd0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("reset_idle", 4'd0, 6'd35, 1'b0, 1'b1);

    foreach (vecs[i])
      for (int c = 0; c < vecs[i].len; c++)
        step(vecs[i].name, vecs[i].seq[c], vecs[i].op, vecs[i].zero, 1'b1);

    step("illegal1_fetch", 4'd1, 6'd1, 1'b0, 1'b1);
    step("illegal1_decode", 4'd2, 6'd1, 1'b0, 1'b1);

    // Fetch stalls three cycles before the instruction word arrives.
    for (int c = 0; c < 3; c++) step("fetch_stall", 4'd1, 6'd2, 1'b0, 1'b0);
    step("fetch_ready", 4'd1, 6'd2, 1'b0, 1'b1);
    step("j_decode", 4'd2, 6'd2, 1'b0, 1'b1);
    step("j_jump", 4'd11, 6'd2, 1'b0, 1'b1);

    // Load: ready arrives in the last cycle before the timeout would fire.
    step("lw_lastcall_fetch", 4'd1, 6'd35, 1'b0, 1'b1);
    step("lw_lastcall_decode", 4'd2, 6'd35, 1'b0, 1'b1);
    step("lw_lastcall_memadr", 4'd3, 6'd35, 1'b0, 1'b0);
    for (int c = 0; c < 15; c++) step("lw_lastcall_wait", 4'd4, 6'd35, 1'b0, 1'b0);
    step("lw_lastcall_ready", 4'd4, 6'd35, 1'b0, 1'b1);
    step("lw_lastcall_memwb", 4'd5, 6'd35, 1'b0, 1'b1);

    // Store aborted by asynchronous reset while stalled in MEMWR.
    step("sw_abort_fetch", 4'd1, 6'd43, 1'b0, 1'b1);
    step("sw_abort_decode", 4'd2, 6'd43, 1'b0, 1'b1);
    step("sw_abort_memadr", 4'd3, 6'd43, 1'b0, 1'b0);
    step("sw_abort_memwr", 4'd6, 6'd43, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("sw_abort_async_reset", sample(), exp_out(4'd0, 6'd43, 1'b0, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step("sw_abort_refetch", 4'd1, 6'd35, 1'b0, 1'b1);

    // Load whose data never comes back: 16 stalled cycles then HALT.
    step("lw_timeout_decode", 4'd2, 6'd35, 1'b0, 1'b1);
    step("lw_timeout_memadr", 4'd3, 6'd35, 1'b0, 1'b0);
    for (int c = 0; c < 16; c++) step("lw_timeout_wait", 4'd4, 6'd35, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++)
      step("halt_hold", 4'd12, 6'd35, 1'b0, logic'(c[0]));
    rst_n = 1'b0;
    #1;
    check("halt_reset_clears", sample(), exp_out(4'd0, 6'd35, 1'b0, 1'b1));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step("post_halt_fetch", 4'd1, 6'd2, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
